// File: rtl/adc_display_conditioner_if.sv
// Sample input, freeze control and held display output of the ADC display conditioner.
// The master side drives samples and freeze; the slave side is the conditioner.
interface adc_display_conditioner_if #(
    parameter int unsigned DATA_W = 12
) ();
    logic [DATA_W-1:0] adc_data;
    logic              adc_valid;
    logic              freeze;
    logic [15:0]       disp_value;
    logic              disp_update;
    logic              pending;

    modport master (
        output adc_data, adc_valid, freeze,
        input  disp_value, disp_update, pending
    );

    modport slave (
        input  adc_data, adc_valid, freeze,
        output disp_value, disp_update, pending
    );
endinterface

// File: rtl/adc_display_conditioner.sv
// Averages 2^LOG2_N ADC samples, scales the average to millivolts, and presents
// the latest result on a display value that is refreshed at most once per hold period.
module adc_display_conditioner #(
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned LOG2_N      = 4,
    parameter int unsigned VREF_MV     = 3300,
    parameter int unsigned HOLD_CYCLES = 25000000
) (
    input  logic                      clk,
    input  logic                      rst,
    adc_display_conditioner_if.slave  bus
);
    localparam int unsigned ACC_W  = DATA_W + LOG2_N;
    localparam int unsigned MV_W   = 20;
    localparam int unsigned PROD_W = DATA_W + MV_W;
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_next;
    logic [ACC_W-1:0]  sum_reg;
    logic [LOG2_N-1:0] cnt;
    logic              sum_valid;

    logic [DATA_W-1:0] avg;
    logic [PROD_W-1:0] prod;
    logic [MV_W-1:0]   mv;
    logic [15:0]       mv_sat;

    logic [HOLD_W-1:0] hold_cnt;
    logic              tick;
    logic              show;
    logic [15:0]       pend_reg;
    logic              pending_q;
    logic [15:0]       disp_value_q;
    logic              disp_update_q;

    assign acc_next = acc + ACC_W'(bus.adc_data);

    // Accumulate; the Nth sample lands in sum_reg and the next sample starts a fresh sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            sum_reg   <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            if (bus.adc_valid) begin
                if (cnt == '1) begin
                    sum_reg   <= acc_next;
                    sum_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= acc_next;
                    cnt <= cnt + LOG2_N'(1);
                end
            end
        end
    end

    // Average, scale to mV and saturate to the 16-bit display range.
    always_comb begin
        avg    = DATA_W'(sum_reg >> LOG2_N);
        prod   = PROD_W'(avg) * PROD_W'(VREF_MV);
        mv     = MV_W'(prod >> DATA_W);
        mv_sat = (mv > MV_W'(16'hFFFF)) ? 16'hFFFF : mv[15:0];
    end

    assign tick = (hold_cnt == HOLD_MAX);
    assign show = tick & pending_q & ~bus.freeze;

    // Hold timer and display update; a same-cycle new result replaces pend_reg after it is shown.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt      <= '0;
            pend_reg      <= '0;
            pending_q     <= 1'b0;
            disp_value_q  <= '0;
            disp_update_q <= 1'b0;
        end else begin
            hold_cnt      <= tick ? '0 : hold_cnt + HOLD_W'(1);
            disp_update_q <= show;
            if (show) begin
                disp_value_q <= pend_reg;
            end
            if (sum_valid) begin
                pend_reg  <= mv_sat;
                pending_q <= 1'b1;
            end else if (show) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign bus.disp_value  = disp_value_q;
    assign bus.disp_update = disp_update_q;
    assign bus.pending     = pending_q;
endmodule

// File: tb/tb_adc_display_conditioner.sv
// Scoreboard bench: two conditioners (VREF 4096 and 100000) share one random/directed stimulus.
module tb_adc_display_conditioner;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned LOG2_N = 2;
    localparam int unsigned N      = 4;
    localparam int unsigned HOLD   = 16;
    localparam int unsigned VREF_A = 4096;
    localparam int unsigned VREF_B = 100000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] s_data  = '0;
    logic              s_valid = 1'b0;
    logic              s_freeze = 1'b0;

    adc_display_conditioner_if #(.DATA_W(DATA_W)) if_a ();
    adc_display_conditioner_if #(.DATA_W(DATA_W)) if_b ();

    assign if_a.adc_data  = s_data;
    assign if_a.adc_valid = s_valid;
    assign if_a.freeze    = s_freeze;
    assign if_b.adc_data  = s_data;
    assign if_b.adc_valid = s_valid;
    assign if_b.freeze    = s_freeze;

    adc_display_conditioner #(.DATA_W(DATA_W), .LOG2_N(LOG2_N), .VREF_MV(VREF_A), .HOLD_CYCLES(HOLD))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    adc_display_conditioner #(.DATA_W(DATA_W), .LOG2_N(LOG2_N), .VREF_MV(VREF_B), .HOLD_CYCLES(HOLD))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sample list, pending value per DUT, tick every HOLD cycles.
    int  m_samples[$];
    int  m_hold = 0;
    bit  m_tick;
    bit  m_stage_valid = 1'b0;
    int  m_stage_val[2];
    int  m_pend_val[2];
    bit  m_pending[2];
    int  m_disp[2];
    int  exp_qa[$];
    int  exp_qb[$];
    int  upd_cnt[2];

    function automatic int to_mv(input int sum, input int unsigned vref);
        longint avg;
        longint mv;
        avg = longint'(sum) / N;
        mv  = (avg * longint'(vref)) / 4096;
        if (mv > 65535) mv = 65535;
        return int'(mv);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_samples.delete();
            m_hold        = 0;
            m_stage_valid = 1'b0;
            for (int d = 0; d < 2; d++) begin
                m_pending[d]  = 1'b0;
                m_pend_val[d] = 0;
                m_disp[d]     = 0;
            end
        end else begin
            m_tick = (m_hold == HOLD - 1);
            m_hold = m_tick ? 0 : m_hold + 1;
            for (int d = 0; d < 2; d++) begin
                if (m_tick && m_pending[d] && !s_freeze) begin
                    m_disp[d]    = m_pend_val[d];
                    m_pending[d] = 1'b0;
                    if (d == 0) exp_qa.push_back(m_pend_val[d]);
                    else        exp_qb.push_back(m_pend_val[d]);
                end
                if (m_stage_valid) begin
                    m_pend_val[d] = m_stage_val[d];
                    m_pending[d]  = 1'b1;
                end
            end
            m_stage_valid = 1'b0;
            if (s_valid) begin
                m_samples.push_back(int'(s_data));
                if (m_samples.size() == N) begin
                    int sum;
                    sum = 0;
                    foreach (m_samples[i]) sum += m_samples[i];
                    m_stage_val[0] = to_mv(sum, VREF_A);
                    m_stage_val[1] = to_mv(sum, VREF_B);
                    m_stage_valid  = 1'b1;
                    m_samples.delete();
                end
            end
        end
    end

    task automatic mon(input int d, input logic upd, input logic [15:0] val, input logic pend);
        int e;
        if (upd) begin
            upd_cnt[d]++;
            if ((d == 0 && exp_qa.size() == 0) || (d == 1 && exp_qb.size() == 0)) begin
                checks++;
                failures++;
                $display("FAIL unexpected_update dut=%0d actual=%0d expected=no_pulse t=%0t", d, val, $time);
            end else begin
                e = (d == 0) ? exp_qa.pop_front() : exp_qb.pop_front();
                check($sformatf("update_value_dut%0d", d), val, e);
            end
        end
        check($sformatf("pending_dut%0d", d), pend, m_pending[d]);
        check($sformatf("held_value_dut%0d", d), val, m_disp[d]);
    endtask

    // Monitor samples outputs on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            mon(0, if_a.disp_update, if_a.disp_value, if_a.pending);
            mon(1, if_b.disp_update, if_b.disp_value, if_b.pending);
        end
    end

    task automatic step(input bit v, input int data);
        s_valid = v;
        s_data  = DATA_W'(data);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0);
    endtask

    task automatic feed4(input int a, input int b, input int c, input int e);
        step(1'b1, a);
        step(1'b1, b);
        step(1'b1, c);
        step(1'b1, e);
    endtask

    int u0;

    initial begin
        upd_cnt[0] = 0;
        upd_cnt[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        idle(100);
        check("idle_disp_a", if_a.disp_value, 0);
        check("idle_pending_a", if_a.pending, 0);
        check("idle_updates_a", upd_cnt[0], 0);

        feed4(100, 200, 300, 400);
        idle(1);
        check("pending_after_avg", if_a.pending, 1);
        u0 = upd_cnt[0];
        idle(20);
        check("avg_250", if_a.disp_value, 250);
        check("avg_250_single_pulse", upd_cnt[0] - u0, 1);
        check("avg_250_pending_clear", if_a.pending, 0);

        for (int i = 0; i < 2 * HOLD && m_hold != 0; i++) idle(1);
        check("aligned_after_tick", m_hold, 0);
        u0 = upd_cnt[0];
        feed4(1, 1, 1, 2);
        feed4(4095, 4095, 4095, 4095);
        idle(20);
        check("back_to_back_latest", if_a.disp_value, 4095);
        check("back_to_back_one_pulse", upd_cnt[0] - u0, 1);
        check("saturated_b", if_b.disp_value, 65535);

        s_freeze = 1'b1;
        feed4(100, 200, 300, 400);
        u0 = upd_cnt[0];
        idle(40);
        check("freeze_hold_value", if_a.disp_value, 4095);
        check("freeze_pending_kept", if_a.pending, 1);
        check("freeze_no_pulse", upd_cnt[0] - u0, 0);
        s_freeze = 1'b0;
        idle(20);
        check("unfreeze_shows_250", if_a.disp_value, 250);

        step(1'b1, 500);
        step(1'b1, 500);
        rst = 1'b1;
        step(1'b0, 0);
        rst = 1'b0;
        feed4(8, 8, 8, 8);
        idle(20);
        check("post_reset_avg_a", if_a.disp_value, 8);
        check("post_reset_avg_b", if_b.disp_value, 195);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) s_freeze = ~s_freeze;
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(4000, 4095)) : int'($urandom_range(0, 4095)));
        end
        s_freeze = 1'b0;
        idle(40);
        check("drain_queue_a", exp_qa.size(), 0);
        check("drain_queue_b", exp_qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
